game_stats: RTL and testbench

//   Upstream bookkeeping stage for the HUD/hex display block. Converts gameplay event

---
 rtl/game_stats.sv | 140 ++++++++++++++
 tb/tb_game_stats.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_stats.sv
// game_stats: turns gameplay event pulses into registered score, health,
// high score and game-state flags for the HUD display block.
module game_stats #(
    parameter logic [7:0]  HEALTH_INIT = 8'hFF,
    parameter logic [7:0]  HIT_DAMAGE  = 8'h40,
    parameter logic [7:0]  KILL_POINTS = 8'h01,
    parameter int unsigned OVER_HOLD   = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       enemy_kill,
    input  logic       player_hit,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic [7:0] health,
    output logic       playing,
    output logic       game_over,
    output logic       new_high
);

    localparam int unsigned CNT_W = $clog2(OVER_HOLD + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PLAYING = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       score_nxt;
    logic [7:0]       health_nxt;
    logic [7:0]       high_nxt;
    logic             new_high_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;

    logic             start_q;
    logic             kill_q;
    logic             hit_q;
    logic             start_ev_c;
    logic             kill_ev_c;
    logic             hit_ev_c;
    logic [8:0]       kill_sum_c;

    // Rising-edge detection against the previous sample of each input
    assign start_ev_c = start      & ~start_q;
    assign kill_ev_c  = enemy_kill & ~kill_q;
    assign hit_ev_c   = player_hit & ~hit_q;

    // Score plus one kill, one bit wider so saturation can be detected
    assign kill_sum_c = {1'b0, score} + {1'b0, KILL_POINTS};

    // Next-state and next-value logic for the game FSM
    always_comb begin
        state_nxt    = state;
        score_nxt    = score;
        health_nxt   = health;
        high_nxt     = high_score;
        new_high_nxt = new_high;
        hold_cnt_nxt = hold_cnt;

        case (state)
            S_IDLE: begin
                if (start_ev_c) begin
                    state_nxt  = S_PLAYING;
                    score_nxt  = 8'h00;
                    health_nxt = HEALTH_INIT;
                end
            end

            S_PLAYING: begin
                if (kill_ev_c) begin
                    score_nxt = kill_sum_c[8] ? 8'hFF : kill_sum_c[7:0];
                end
                if (hit_ev_c) begin
                    if (health <= HIT_DAMAGE) begin
                        // Fatal hit: the compare sees any coincident kill
                        health_nxt   = 8'h00;
                        state_nxt    = S_OVER;
                        hold_cnt_nxt = '0;
                        if (score_nxt > high_score) begin
                            high_nxt     = score_nxt;
                            new_high_nxt = 1'b1;
                        end else begin
                            new_high_nxt = 1'b0;
                        end
                    end else begin
                        health_nxt = health - HIT_DAMAGE;
                    end
                end
            end

            S_OVER: begin
                if (hold_cnt == CNT_W'(OVER_HOLD - 1)) begin
                    state_nxt    = S_IDLE;
                    new_high_nxt = 1'b0;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                new_high_nxt = 1'b0;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // State register, edge-detect history and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            score      <= 8'h00;
            high_score <= 8'h00;
            health     <= HEALTH_INIT;
            playing    <= 1'b0;
            game_over  <= 1'b0;
            new_high   <= 1'b0;
            hold_cnt   <= '0;
            start_q    <= 1'b0;
            kill_q     <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            score      <= score_nxt;
            high_score <= high_nxt;
            health     <= health_nxt;
            playing    <= (state_nxt == S_PLAYING);
            game_over  <= (state_nxt == S_OVER);
            new_high   <= new_high_nxt;
            hold_cnt   <= hold_cnt_nxt;
            start_q    <= start;
            kill_q     <= enemy_kill;
            hit_q      <= player_hit;
        end
    end

endmodule

// File: tb/tb_game_stats.sv
// tb_game_stats: directed test of game_stats with a short OVER hold.
`timescale 1ns/1ps
module tb_game_stats;

    logic       clk;
    logic       reset;
    logic       start;
    logic       enemy_kill;
    logic       player_hit;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [7:0] health;
    logic       playing;
    logic       game_over;
    logic       new_high;

    int n_checks;
    int n_errors;

    game_stats #(
        .HEALTH_INIT(8'hFF),
        .HIT_DAMAGE (8'h40),
        .KILL_POINTS(8'h01),
        .OVER_HOLD  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .enemy_kill(enemy_kill),
        .player_hit(player_hit),
        .score     (score),
        .high_score(high_score),
        .health    (health),
        .playing   (playing),
        .game_over (game_over),
        .new_high  (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle pulse on the selected inputs, then one low cycle
    task automatic pulse(input logic s, input logic k, input logic h);
        @(negedge clk);
        start      = s;
        enemy_kill = k;
        player_hit = h;
        @(negedge clk);
        start      = 1'b0;
        enemy_kill = 1'b0;
        player_hit = 1'b0;
    endtask

    // Wait (bounded) for the OVER hold to end
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (game_over === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(game_over), 32'd0);
    endtask

    // Play a full game reaching the given score, then die with four hits
    task automatic play_game(input int kills, input logic [7:0] exp_high,
                             input logic exp_new, input string tag);
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < kills; i++) pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0, 1'b1);
        check({tag, "_over"},  32'(game_over),  32'd1);
        check({tag, "_high"},  32'(high_score), 32'(exp_high));
        check({tag, "_new"},   32'(new_high),   32'(exp_new));
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        int n;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        enemy_kill = 1'b0;
        player_hit = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_score",    32'(score),      32'h00);
        check("rst_high",     32'(high_score), 32'h00);
        check("rst_health",   32'(health),     32'hFF);
        check("rst_playing",  32'(playing),    32'd0);
        check("rst_over",     32'(game_over),  32'd0);
        check("rst_new_high", 32'(new_high),   32'd0);

        // Kills in IDLE before any game are ignored
        pulse(1'b0, 1'b1, 1'b0);
        check("idle_kill0", 32'(score), 32'h00);

        // Start
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_playing", 32'(playing), 32'd1);
        check("t1_score",   32'(score),   32'h00);
        check("t1_health",  32'(health),  32'hFF);
        check("t1_high",    32'(high_score), 32'h00);

        // Three kill pulses, then a held level counts once
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0);
        check("t2_three", 32'(score), 32'h03);
        @(negedge clk);
        enemy_kill = 1'b1;
        repeat (10) @(negedge clk);
        enemy_kill = 1'b0;
        @(negedge clk);
        check("t2_held", 32'(score), 32'h04);

        // Hits down to zero
        pulse(1'b0, 1'b0, 1'b1);
        check("t3_hp1", 32'(health), 32'hBF);
        pulse(1'b0, 1'b0, 1'b1);
        check("t3_hp2", 32'(health), 32'h7F);
        pulse(1'b0, 1'b0, 1'b1);
        check("t3_hp3", 32'(health), 32'h3F);
        check("t3_still_playing", 32'(playing), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        check("t3_hp4",      32'(health),     32'h00);
        check("t3_playing",  32'(playing),    32'd0);
        check("t3_over",     32'(game_over),  32'd1);
        check("t3_new_high", 32'(new_high),   32'd1);
        check("t3_high",     32'(high_score), 32'h04);
        // Start during OVER is ignored; count the OVER cycles
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (game_over === 1'b1 && n < 50) begin
            @(negedge clk);
            if (game_over === 1'b1) n++;
        end
        check("t3_hold_len",   32'(n),        32'd8);
        check("t3_idle_play",  32'(playing),  32'd0);
        check("t3_idle_new",   32'(new_high), 32'd0);
        check("t3_keep_score", 32'(score),    32'h04);
        check("t3_keep_hp",    32'(health),   32'h00);
        pulse(1'b0, 1'b1, 1'b0);
        check("t2_idle_kill",  32'(score),    32'h04);

        // High-score tracking across games
        play_game(5, 8'h05, 1'b1, "t5_g1");
        play_game(3, 8'h05, 1'b0, "t5_g2");
        check("t5_g2_score", 32'(score), 32'h03);
        play_game(5, 8'h05, 1'b0, "t5_g3");

        // Kill coincident with the fatal hit
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1, 1'b0);
        check("t6_pre_score", 32'(score),  32'h06);
        check("t6_pre_hp",    32'(health), 32'h3F);
        pulse(1'b0, 1'b1, 1'b1);
        check("t6_score", 32'(score),      32'h07);
        check("t6_high",  32'(high_score), 32'h07);
        check("t6_new",   32'(new_high),   32'd1);
        check("t6_over",  32'(game_over),  32'd1);
        wait_idle("t6_idle");

        // Saturating score
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) pulse(1'b0, 1'b1, 1'b0);
        check("t4_255", 32'(score), 32'hFF);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0);
        check("t4_260", 32'(score), 32'hFF);
        check("t4_playing", 32'(playing), 32'd1);

        // Asynchronous reset mid-game, away from any clock edge
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_score",   32'(score),      32'h00);
        check("ar_high",    32'(high_score), 32'h00);
        check("ar_health",  32'(health),     32'hFF);
        check("ar_playing", 32'(playing),    32'd0);
        check("ar_over",    32'(game_over),  32'd0);
        check("ar_new",     32'(new_high),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
